// File: rtl/cavlc_scan_ctrl.sv
// CAVLC block scan controller: reads a 4x4 coefficient block in reverse zigzag order,
// streams it to the external total-zero counter and derives total_coeff / trailing-ones info.
module cavlc_scan_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       blk_valid,
  output logic       blk_ready,
  output logic       rd_en,
  output logic [3:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic [7:0] coeff_o,
  output logic       coeff_vld,
  output logic       cnt_rst,
  input  logic [3:0] total_zero_cnt,
  output logic [4:0] total_coeff,
  output logic [1:0] trailing_ones,
  output logic [2:0] t1_signs,
  output logic [3:0] total_zeros,
  output logic       res_valid,
  input  logic       res_ready
);

  // state   | meaning
  // IDLE    | waiting for a block, counter held clear
  // SCAN    | issuing reads idx 15 down to 0
  // DRAIN   | last read's data (idx 0) on coeff_o
  // CAPTURE | latch the zero count
  // OUT     | result presented until res_ready
  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, CAPTURE, OUT} state_t;

  state_t     state, state_nxt;
  logic [3:0] idx;
  logic       accept;
  logic       t1_active;
  logic       nonzero;
  logic       is_t1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    blk_ready = 1'b0;
    cnt_rst   = 1'b1;
    rd_en     = 1'b0;
    rd_addr   = 4'd0;
    res_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        blk_ready = 1'b1;
        if (blk_valid) begin
          accept    = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        cnt_rst = 1'b0;
        rd_en   = 1'b1;
        rd_addr = idx;
        if (idx == 4'd0) state_nxt = DRAIN;
      end
      DRAIN: begin
        cnt_rst   = 1'b0;
        state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = OUT;
      OUT: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= 4'd15;
      coeff_vld <= 1'b0;
    end else begin
      coeff_vld <= rd_en;
      if (accept)              idx <= 4'd15;
      else if (state == SCAN)  idx <= idx - 4'd1;
    end
  end

  // Gate the stream so the counter sees zero whenever no read data is due.
  assign coeff_o = coeff_vld ? rd_data : 8'h00;
  assign nonzero = coeff_vld && (coeff_o != 8'h00);
  assign is_t1   = (coeff_o == 8'h01) || (coeff_o == 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_coeff   <= 5'd0;
      trailing_ones <= 2'd0;
      t1_signs      <= 3'd0;
      total_zeros   <= 4'd0;
      t1_active     <= 1'b0;
    end else begin
      if (accept) begin
        total_coeff   <= 5'd0;
        trailing_ones <= 2'd0;
        t1_signs      <= 3'd0;
        total_zeros   <= 4'd0;
        t1_active     <= 1'b1;
      end else if (nonzero) begin
        total_coeff <= total_coeff + 5'd1;
        // Tracking ends for good at the first non-unit coefficient or the third trailing one.
        if (t1_active) begin
          if (is_t1) begin
            case (trailing_ones)
              2'd0:    t1_signs[0] <= coeff_o[7];
              2'd1:    t1_signs[1] <= coeff_o[7];
              default: t1_signs[2] <= coeff_o[7];
            endcase
            trailing_ones <= trailing_ones + 2'd1;
            if (trailing_ones == 2'd2) t1_active <= 1'b0;
          end else begin
            t1_active <= 1'b0;
          end
        end
      end
      if (state == CAPTURE) total_zeros <= total_zero_cnt;
    end
  end

endmodule

// File: tb/tb_cavlc_scan_ctrl.sv
// Self-checking bench for cavlc_scan_ctrl: directed and random blocks against a
// block-level reference model, with a behavioural coefficient buffer and zero counter.
module tb_cavlc_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       blk_valid = 1'b0;
  logic       res_ready = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic [3:0] total_zero_cnt;
  logic       blk_ready, rd_en, coeff_vld, cnt_rst, res_valid;
  logic [3:0] rd_addr, total_zeros;
  logic [7:0] coeff_o;
  logic [4:0] total_coeff;
  logic [1:0] trailing_ones;
  logic [2:0] t1_signs;

  cavlc_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .coeff_o(coeff_o),
    .coeff_vld(coeff_vld), .cnt_rst(cnt_rst), .total_zero_cnt(total_zero_cnt),
    .total_coeff(total_coeff), .trailing_ones(trailing_ones), .t1_signs(t1_signs),
    .total_zeros(total_zeros), .res_valid(res_valid), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cur_cyc = 0;
  logic [7:0] buffer [16];
  int exp_tc, exp_t1, exp_sg, exp_tz;

  // Coefficient buffer: data one cycle after the strobe, garbage otherwise.
  always @(posedge clk) rd_data <= rd_en ? buffer[rd_addr] : 8'($urandom);

  // External total-zero counter: zeros seen after the first nonzero of the stream.
  logic [3:0] tz_cnt = 4'd0;
  logic       tz_seen = 1'b0;
  always @(posedge clk) begin
    if (cnt_rst) begin
      tz_cnt  <= 4'd0;
      tz_seen <= 1'b0;
    end else if (coeff_o != 8'h00) tz_seen <= 1'b1;
    else if (tz_seen)              tz_cnt  <= tz_cnt + 4'd1;
  end
  assign total_zero_cnt = tz_cnt;

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cur_cyc, obs, expv);
    end
  endtask

  // Reference: scan order is index 15 down to 0.
  function automatic void model();
    int  last_nz;
    exp_tc = 0; exp_t1 = 0; exp_sg = 0; exp_tz = 0; last_nz = -1;
    for (int i = 15; i >= 0; i--)
      if (buffer[i] != 8'h00) begin
        exp_tc++;
        last_nz = i;
      end
    if (exp_tc > 0) begin
      for (int i = 15; i >= 0; i--)
        if (buffer[i] != 8'h00) begin
          for (int j = i - 1; j >= 0; j--) if (buffer[j] == 8'h00) exp_tz++;
          break;
        end
    end
    for (int i = 15; i >= 0; i--) begin
      if (buffer[i] == 8'h00) continue;
      if ((buffer[i] == 8'h01 || buffer[i] == 8'hFF) && exp_t1 < 3) begin
        if (buffer[i] == 8'hFF) exp_sg |= (1 << exp_t1);
        exp_t1++;
      end else break;
    end
    if (last_nz < 0) exp_tz = 0;
  endfunction

  task automatic check_reset_vals();
    chk("rst_blk_ready", 32'(blk_ready), 1);
    chk("rst_cnt_rst", 32'(cnt_rst), 1);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_coeff_vld", 32'(coeff_vld), 0);
    chk("rst_coeff_o", 32'(coeff_o), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_total_coeff", 32'(total_coeff), 0);
    chk("rst_trailing_ones", 32'(trailing_ones), 0);
    chk("rst_t1_signs", 32'(t1_signs), 0);
    chk("rst_total_zeros", 32'(total_zeros), 0);
  endtask

  task automatic check_results();
    chk("total_coeff", 32'(total_coeff), 32'(exp_tc));
    chk("trailing_ones", 32'(trailing_ones), 32'(exp_t1));
    chk("t1_signs", 32'(t1_signs), 32'(exp_sg));
    chk("total_zeros", 32'(total_zeros), 32'(exp_tz));
  endtask

  // Entered at a falling edge with the DUT idle; rst_at>0 pulses reset in that cycle.
  task automatic run_block(input int hold, input int rst_at);
    model();
    blk_valid = 1'b1;
    cur_cyc = 0;
    chk("idle_blk_ready", 32'(blk_ready), 1);
    @(posedge clk);
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      cur_cyc = c;
      chk("rd_en", 32'(rd_en), (c <= 16) ? 1 : 0);
      chk("rd_addr", 32'(rd_addr), (c <= 16) ? 32'(16 - c) : 0);
      chk("coeff_vld", 32'(coeff_vld), (c >= 2 && c <= 17) ? 1 : 0);
      chk("coeff_o", 32'(coeff_o), (c >= 2 && c <= 17) ? 32'(buffer[17 - c]) : 0);
      chk("cnt_rst", 32'(cnt_rst), (c <= 17) ? 0 : 1);
      chk("busy_blk_ready", 32'(blk_ready), 0);
      chk("res_valid", 32'(res_valid), (c == 19) ? 1 : 0);
      if (c == 19) check_results();
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        blk_valid = 1'b0;
        res_ready = 1'b0;
        @(negedge clk);
        return;
      end
      blk_valid = 1'($urandom);
      res_ready = (c < 19) ? 1'($urandom) : 1'b0;
    end
    blk_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      cur_cyc++;
      chk("hold_res_valid", 32'(res_valid), 1);
      chk("hold_blk_ready", 32'(blk_ready), 0);
      check_results();
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cur_cyc++;
    res_ready = 1'b0;
    chk("post_res_valid", 32'(res_valid), 0);
    chk("post_blk_ready", 32'(blk_ready), 1);
  endtask

  task automatic clear_buf();
    for (int i = 0; i < 16; i++) buffer[i] = 8'h00;
  endtask

  task automatic rand_buf();
    int r;
    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 7);
      if (r < 4)       buffer[i] = 8'h00;
      else if (r == 4) buffer[i] = 8'h01;
      else if (r == 5) buffer[i] = 8'hFF;
      else             buffer[i] = 8'($urandom);
    end
  endtask

  initial begin
    clear_buf();
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);

    clear_buf();
    buffer[0] = 8'h05; buffer[2] = 8'hFF; buffer[3] = 8'h01;
    run_block(0, 0);
    chk("dir1_total_coeff", 32'(exp_tc), 3);
    chk("dir1_t1_signs", 32'(exp_sg), 3'b010);

    clear_buf();
    run_block(1, 0);

    for (int i = 0; i < 16; i++) buffer[i] = 8'h01;
    run_block(0, 0);

    clear_buf();
    buffer[15] = 8'h01; buffer[14] = 8'h02; buffer[13] = 8'hFF;
    run_block(5, 0);

    rand_buf();
    run_block(0, 9);
    check_reset_vals();
    clear_buf();
    buffer[0] = 8'h05; buffer[2] = 8'hFF; buffer[3] = 8'h01;
    run_block(0, 0);

    rand_buf();
    run_block(0, 19);
    check_reset_vals();

    for (int n = 0; n < 30; n++) begin
      rand_buf();
      run_block($urandom_range(0, 5), 0);
    end

    blk_valid = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cavlc_scan_ctrl.md
CAVLC_SCAN_CTRL -- requirements
Module: cavlc_scan_ctrl

Interface
Parameters: none; block size fixed at 16 coefficients, 8-bit signed two's complement.
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Port clk, input, 1: sole clock, rising edge.
REQ-003 Port rst_n, input, 1: asynchronous active-low reset.
REQ-004 Port blk_valid, input, 1: a 4x4 block is ready in the coefficient buffer.
REQ-005 Port blk_ready, output, 1: controller can accept a block.
REQ-006 Port rd_en, output, 1: coefficient buffer read strobe.
REQ-007 Port rd_addr, output, 4: zigzag index to read.
REQ-008 Port rd_data, input, 8: buffer data, valid exactly 1 cycle after rd_en.
REQ-009 Port coeff_o, output, 8: coefficient stream to the total-zero counter.
REQ-010 Port coeff_vld, output, 1: coeff_o carries a scanned coefficient.
REQ-011 Port cnt_rst, output, 1: synchronous clear for the total-zero counter.
REQ-012 Port total_zero_cnt, input, 4: counter result.
REQ-013 Ports total_coeff (5), trailing_ones (2), t1_signs (3), total_zeros (4), outputs: block result.
REQ-014 Port res_valid, output, 1, and res_ready, input, 1: result handshake.

Function
REQ-015 FSM states IDLE, SCAN, DRAIN, CAPTURE, OUT; the reset state is IDLE.
REQ-016 IDLE: blk_ready=1, cnt_rst=1; on blk_valid=1, go to SCAN with idx=15.
REQ-017 SCAN: rd_en=1, rd_addr=idx, idx decrements each cycle; after issuing idx=0, go to DRAIN (16 SCAN cycles).
REQ-018 coeff_vld SHALL be rd_en delayed 1 cycle; coeff_o=rd_data when coeff_vld=1, else 8'h00 (the counter must never see garbage).
REQ-019 cnt_rst SHALL be 0 in SCAN and DRAIN, and 1 in IDLE, CAPTURE and OUT.
REQ-020 DRAIN: the last coefficient (idx 0) is presented; go to CAPTURE next cycle.
REQ-021 CAPTURE: latch total_zeros<=total_zero_cnt; go to OUT.
REQ-022 OUT: res_valid=1; result outputs are held stable until res_ready=1 is sampled, then go to IDLE.
REQ-023 Latency: accept at edge E0; SCAN in cycles 1-16; coeff_vld in cycles 2-17; CAPTURE in cycle 18; res_valid from cycle 19 onward.
REQ-024 total_coeff: count of coeff_vld cycles with coeff_o!=0, range 0-16, cleared on block accept.
REQ-025 trailing_ones: while T1 tracking is active, each nonzero equal to 8'h01 or 8'hFF increments the count, saturating at 3.
REQ-026 T1 tracking SHALL stop permanently at the first nonzero that is not +/-1, or once the count reaches 3.
REQ-027 t1_signs[k] SHALL be 1 if the k-th trailing one (in scan order) is 8'hFF; unused bits are 0.
REQ-028 Zeros SHALL NOT affect T1 tracking.
REQ-029 blk_valid outside IDLE SHALL be ignored (blk_ready=0).
REQ-030 res_ready outside OUT SHALL be ignored.
REQ-031 Back-to-back blocks: the earliest next accept is the cycle after the OUT->IDLE transition.

Reset
REQ-032 With rst_n=0, asynchronously: state=IDLE; idx=15; blk_ready=1; cnt_rst=1; rd_en=0; rd_addr=0; coeff_vld=0; coeff_o=0; res_valid=0; all result outputs 0.
REQ-033 Reset mid-SCAN or mid-OUT SHALL abandon the block with no partial result; after rst_n deasserts, the next accept starts a fresh scan at idx 15.

Verification
REQ-034 Buffer idx0=8'h05, idx1=00, idx2=FF, idx3=01, rest 00 -> total_coeff=3, trailing_ones=2, t1_signs=3'b010, total_zeros=1, res_valid at cycle 19.
REQ-035 All-zero block -> total_coeff=0, trailing_ones=0, t1_signs=0, total_zeros=0; cnt_rst=0 only in cycles 1-17.
REQ-036 All 16 = 8'h01 -> total_coeff=16, trailing_ones=3, t1_signs=000, total_zeros=0.
REQ-037 idx15=01, idx14=02, idx13=FF, rest 00 -> total_coeff=3, trailing_ones=1, t1_signs=000, total_zeros=13.
REQ-038 res_ready low for 5 cycles in OUT, with blk_valid held high -> outputs stable, blk_ready=0; accept occurs the cycle after the handshake.
REQ-039 rst_n pulsed low at SCAN idx=7 -> all outputs at reset values immediately; the next block scans from rd_addr=15 and produces correct results.
